// File: rtl/booth_mult_pkg.sv
// Shared constants and FSM state encoding for the shared Booth multiplier arbiter.
package booth_mult_pkg;

  localparam int OP_W    = 8;
  localparam int PROD_W  = 16;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/booth_mult.sv
// Combinational radix-4 Booth multiplier, 8x8 signed -> 16-bit signed.
module booth_mult (
  input  logic signed [7:0]  A,
  input  logic signed [7:0]  B,
  output logic signed [15:0] C
);

  // One radix-4 partial product for a 3-bit Booth digit.
  function automatic logic signed [15:0] booth_pp(input logic signed [7:0] a,
                                                  input logic [2:0]        code);
    logic signed [15:0] ax;
    logic signed [15:0] pp;
    ax = {{8{a[7]}}, a};
    case (code)
      3'b001, 3'b010: pp = ax;
      3'b011:         pp = ax <<< 1;
      3'b100:         pp = -(ax <<< 1);
      3'b101, 3'b110: pp = -ax;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

  logic [8:0]         b_ext;
  logic signed [15:0] acc;

  // Sum the four shifted partial products; the result wraps exactly at 16 bits.
  always_comb begin
    b_ext = {B, 1'b0};
    acc   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      acc = acc + (booth_pp(A, b_ext[2*i +: 3]) << (2*i));
    end
    C = acc;
  end

endmodule

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after the last grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  int unsigned     idx;
  logic [ID_W-1:0] sel;
  logic            found;

  // Walk last+1 .. last+NUM_REQ (mod NUM_REQ); first set request wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last) + k) % 32'(NUM_REQ);
      sel = idx[ID_W-1:0];
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_id   = sel;
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one booth_mult among NUM_REQ valid/ready requesters with round-robin
// grant, registered operands and a tagged valid/ready response port.
module booth_mult_arbiter
  import booth_mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_product,
  output logic                    busy
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [OP_W-1:0]      op_a_q, op_a_d;
  logic [OP_W-1:0]      op_b_q, op_b_d;
  logic [ID_W-1:0]      op_id_q, op_id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [PROD_W-1:0]    rsp_product_q, rsp_product_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_id;
  logic signed [PROD_W-1:0] mult_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req    (req_valid),
    .last   (last_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  booth_mult u_mult (
    .A (op_a_q),
    .B (op_b_q),
    .C (mult_c)
  );

  // Next-state, grant and datapath register updates.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_id_d       = op_id_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    req_ready     = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          // Gated by rst_n so no ready is shown during a reset cycle.
          req_ready = gnt & {NUM_REQ{rst_n}};
          op_a_d    = req_a[gnt_id*OP_W +: OP_W];
          op_b_d    = req_b[gnt_id*OP_W +: OP_W];
          op_id_d   = gnt_id;
          last_d    = gnt_id;
          state_d   = CALC;
        end
      end
      CALC: begin
        rsp_product_d = mult_c;
        rsp_id_d      = op_id_q;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= ID_W'(NUM_REQ - 1);
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_id_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_id_q       <= op_id_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Shares one combinational `booth_mult` (8×8 signed → 16-bit signed) between `NUM_REQ` requesters. Each requester uses a valid/ready handshake. A round-robin grant picks one request at a time, the operands are registered, and the product is returned through a single valid/ready response port tagged with the requester index. The block sits between the client datapaths and the only multiplier instance, so that instance carries no combinational fan-in from the clients.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index. Derived; do not override.
- `clk`, input, 1: the single clock. All flops use the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `req_valid`, input, `NUM_REQ`: per-requester request valid.
- `req_ready`, output, `NUM_REQ`: per-requester accept. One-hot or zero.
- `req_a`, input, `NUM_REQ*8`: packed signed multiplicands. Requester i uses bits `[8i+7:8i]`.
- `req_b`, input, `NUM_REQ*8`: packed signed multipliers, same packing as `req_a`.
- `rsp_valid`, output, 1: response valid.
- `rsp_ready`, input, 1: response consumer accept.
- `rsp_id`, output, `ID_W`: index of the requester that owns `rsp_product`.
- `rsp_product`, output, 16: signed product, `a*b`.
- `busy`, output, 1: high whenever the FSM is not in `IDLE`.

## Operation
- FSM states are `IDLE`, `CALC` and `RESP`.
- **`IDLE`**
  - If any `req_valid` bit is set, the round-robin winner `g` sees `req_ready[g]=1`. Every other `req_ready` bit is 0.
  - The handshake completes on that edge: `op_a`, `op_b` and `op_id` are registered from requester `g`, and the FSM moves to `CALC`.
  - If no `req_valid` bit is set, the FSM stays in `IDLE` and all `req_ready` bits are 0.
- **`CALC`**
  - `op_a` and `op_b` drive `booth_mult` directly.
  - At the end of the cycle, its output is registered into `rsp_product`, `op_id` into `rsp_id`, and `rsp_valid` is set to 1. The FSM moves to `RESP`.
- **`RESP`**
  - `rsp_valid`, `rsp_id` and `rsp_product` hold stable until `rsp_valid && rsp_ready`.
  - On that handshake edge, `rsp_valid` goes to 0 and the FSM moves to `IDLE`.
- **Round-robin**
  - The `last` register holds the last granted index.
  - The search starts at `last+1`, wraps modulo `NUM_REQ`, and the first set `req_valid` wins.
  - `last` updates only on a completed request handshake.
- **Requester rules**
  - Once `req_valid` is high, the requester holds `req_a` and `req_b` stable until it sees `req_ready`.
  - A requester may deassert `req_valid` before it is granted. It then drops out of arbitration with no side effects.
- **Arithmetic**
  - The full signed 16-bit product never overflows. The extreme case is −128 × −128 = 16384 (0x4000).
  - No truncation and no saturation.

## Timing
- Reset (`rst_n=0` sampled at an edge) gives:
  - state = `IDLE`, `last` = `NUM_REQ-1`, so requester 0 has first priority;
  - `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0;
  - `busy`=0, every `req_ready` bit = 0 for that cycle.
- Reset in `CALC` or `RESP` discards the transaction in flight. No response is produced for it.
- `req_ready` is a combinational function of the state, `last` and `req_valid`. It does not depend on `rsp_ready`.
- Latency: request handshake at edge N gives `rsp_valid` high after edge N+1. With `rsp_ready` held at 1, the response handshake is at edge N+2.
- Minimum spacing between request accepts is 3 cycles. The next grant is at edge N+3 at the earliest.
- Back-pressure: while `rsp_ready`=0 the FSM stays in `RESP` indefinitely, and every `req_ready` bit stays 0.
- Requests that arrive together are resolved only by the round-robin order. There is never more than one grant per cycle.

## Structure
- Shared package `booth_mult_pkg` holds:
  - `OP_W=8` and `PROD_W=16`;
  - the state enum, `IDLE`=2'd0, `CALC`=2'd1, `RESP`=2'd2;
  - `STATE_W`.
- Sub-module `rr_arbiter` (parameter `NUM_REQ`):
  - inputs `req` and `last`;
  - outputs one-hot `gnt` and encoded `gnt_id`;
  - purely combinational.
- Instantiate the existing `booth_mult` once, with `.A(op_a)`, `.B(op_b)`, `.C(mult_c)`.

## Test plan
- **Single requester, back-to-back vectors.**
  - Stimulus: requester 0 only, `rsp_ready`=1, issuing in order:
    - 0x99 × 0x39,
    - 0x7C × 0x32,
    - 0xC4 × 0xFC,
    - 0xFA × 0xF3.
  - Required: `rsp_product` = 0xE911, 0x1838, 0x00F0, 0x004E in that order, each with `rsp_id`=0. Accepts are exactly 3 cycles apart.
- **All requesters simultaneous.**
  - Stimulus: `NUM_REQ`=4, all four `req_valid` high from reset release, requester i sending a=i+1, b=−2.
  - Required: grant order 0,1,2,3. `rsp_id` 0..3 with products 0xFFFE, 0xFFFC, 0xFFFA, 0xFFF8.
- **Back-pressure.**
  - Stimulus: hold `rsp_ready`=0 for 10 cycles during `RESP`.
  - Required: `rsp_valid`, `rsp_id` and `rsp_product` stay stable, and every `req_ready` bit is 0. After `rsp_ready` rises, the next grant occurs one cycle after the response handshake.
- **Extremes.**
  - Stimulus: 0x80 × 0x80, then 0x80 × 0x7F.
  - Required: 0x4000, then 0xC080.
- **Fairness and wrap-around.**
  - Stimulus: requesters 1 and 3 continuously valid.
  - Required: grants alternate 1,3,1,3. Neither requester is starved.
- **Reset mid-operation.**
  - Stimulus: assert `rst_n`=0 for one edge while in `CALC`.
  - Required: `rsp_valid` stays 0 and no response is emitted. The next grant goes to requester 0 if it is valid.
